hough_accumulator: RTL and testbench

HOUGH_ACCUMULATOR -- requirements
Module: hough_accumulator

---
 rtl/hough_accumulator_pkg.sv | 27 ++
 rtl/hough_accum_ram.sv | 40 ++++
 rtl/hough_accumulator.sv | 148 ++++++++++++++
 tb/tb_hough_accumulator.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hough_accumulator_pkg.sv
// Shared constants, FSM encoding and pipeline payload for the Hough vote accumulator.
package hough_accumulator_pkg;

  localparam int unsigned DEF_N_ANGLE  = 180;
  localparam int unsigned DEF_R_OFFSET = 800;
  localparam int unsigned DEF_R_SHIFT  = 3;
  localparam int unsigned DEF_CNT_W    = 8;
  localparam int unsigned ADDR_W       = 16;
  localparam int unsigned ANGLE_W      = 8;
  localparam int unsigned RBIN_W       = 8;
  localparam int unsigned VOTE_R_W     = 13;
  localparam int unsigned BIASED_W     = 14;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } vote_slot_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ANGLE_W-1:0] angle,
                                                  input logic [RBIN_W-1:0]  r_bin);
    return {angle, r_bin};
  endfunction

endpackage

// File: rtl/hough_accum_ram.sv
// 64K-cell accumulator RAM: pipeline write/read port plus a readout port with an extra output register.
module hough_accum_ram
  import hough_accumulator_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rda_addr,
  output logic [CNT_W-1:0]  rda_data,
  input  logic [ADDR_W-1:0] rdb_addr,
  output logic [CNT_W-1:0]  rdb_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [CNT_W-1:0] mem [0:DEPTH-1];
  logic [CNT_W-1:0] rdb_raw;

  // Read-first array: a same-edge read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rda_data <= mem[rda_addr];
    rdb_raw  <= mem[rdb_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdb_data <= '0;
    end else begin
      rdb_data <= rdb_raw;
    end
  end

endmodule

// File: rtl/hough_accumulator.sv
// Hough-space vote accumulator: binned (angle, r) votes, saturating counters, peak tracking and bulk clear.
module hough_accumulator
  import hough_accumulator_pkg::*;
#(
  parameter int unsigned N_ANGLE  = DEF_N_ANGLE,
  parameter int unsigned R_OFFSET = DEF_R_OFFSET,
  parameter int unsigned R_SHIFT  = DEF_R_SHIFT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                vote_valid,
  input  logic [ANGLE_W-1:0]  vote_angle,
  input  logic [VOTE_R_W-1:0] vote_r,
  output logic                busy,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [CNT_W-1:0]    rd_data,
  output logic [CNT_W-1:0]    peak_count,
  output logic [ANGLE_W-1:0]  peak_angle,
  output logic [RBIN_W-1:0]   peak_rbin,
  output logic                err_range,
  output logic                err_drop
);

  logic [0:0]          state, state_nxt;
  logic [ADDR_W-1:0]   clr_addr, clr_addr_nxt;
  logic                in_clear, enter_clear;

  logic [BIASED_W-1:0] r_biased;
  logic [BIASED_W-1:0] r_bin_full;
  logic                in_range;
  logic [ADDR_W-1:0]   s0_addr;

  vote_slot_t          s1, s2, last_wr;
  logic [CNT_W-1:0]    last_wr_data;
  logic [CNT_W-1:0]    rda_data;
  logic [CNT_W-1:0]    s2_base, s2_new;

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [CNT_W-1:0]    wr_data;

  // S0: bias, bin and range-check the incoming vote.
  assign r_biased   = {vote_r[VOTE_R_W-1], vote_r} + BIASED_W'(R_OFFSET);
  assign r_bin_full = r_biased >> R_SHIFT;
  assign in_range   = (32'(vote_angle) < N_ANGLE) && !r_biased[BIASED_W-1] &&
                      (r_bin_full <= BIASED_W'(255));
  assign s0_addr    = cell_addr(vote_angle, r_bin_full[RBIN_W-1:0]);

  // S2: the previous write lands on the same edge as our read, so take it from the bypass.
  assign s2_base = (last_wr.valid && (last_wr.addr == s2.addr)) ? last_wr_data : rda_data;
  assign s2_new  = (s2_base == '1) ? s2_base : s2_base + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      clr_addr <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      clr_addr <= clr_addr_nxt;
      busy     <= (state_nxt == ST_CLEAR);
    end
  end

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    in_clear     = (state == ST_CLEAR);
    enter_clear  = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = s2.addr;
    wr_data      = s2_new;
    case (state)
      ST_IDLE: begin
        if (clear) begin
          state_nxt    = ST_CLEAR;
          clr_addr_nxt = '0;
          enter_clear  = 1'b1;
        end
        wr_en = s2.valid && !clear;
      end
      ST_CLEAR: begin
        clr_addr_nxt = clr_addr + ADDR_W'(1);
        wr_en        = 1'b1;
        wr_addr      = clr_addr;
        wr_data      = '0;
        if (clr_addr == '1) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || enter_clear) begin
      s1           <= '0;
      s2           <= '0;
      last_wr      <= '0;
      last_wr_data <= '0;
    end else begin
      s1           <= '{valid: vote_valid && !in_clear && in_range, addr: s0_addr};
      s2           <= s1;
      last_wr      <= '{valid: s2.valid, addr: s2.addr};
      last_wr_data <= s2_new;
    end
  end

  // Sticky error flags and peak tracker; ties keep the earlier peak.
  always_ff @(posedge clk) begin
    if (reset || enter_clear) begin
      err_range  <= 1'b0;
      err_drop   <= 1'b0;
      peak_count <= '0;
      peak_angle <= '0;
      peak_rbin  <= '0;
    end else begin
      if (vote_valid && in_clear) begin
        err_drop <= 1'b1;
      end
      if (vote_valid && !in_clear && !in_range) begin
        err_range <= 1'b1;
      end
      if (s2.valid && (s2_new > peak_count)) begin
        peak_count <= s2_new;
        peak_angle <= s2.addr[ADDR_W-1:RBIN_W];
        peak_rbin  <= s2.addr[RBIN_W-1:0];
      end
    end
  end

  hough_accum_ram #(
    .CNT_W (CNT_W)
  ) u_ram (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rda_addr (s1.addr),
    .rda_data (rda_data),
    .rdb_addr (rd_addr),
    .rdb_data (rd_data)
  );

endmodule

// File: tb/tb_hough_accumulator.sv
// Self-checking bench for hough_accumulator: vector table, directed corner sequences and a random vote stream.
module tb_hough_accumulator;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        vote_valid;
  logic [7:0]  vote_angle;
  logic [12:0] vote_r;
  logic        busy;
  logic [15:0] rd_addr;
  logic [7:0]  rd_data;
  logic [7:0]  peak_count;
  logic [7:0]  peak_angle;
  logic [7:0]  peak_rbin;
  logic        err_range;
  logic        err_drop;

  hough_accumulator dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .vote_valid (vote_valid),
    .vote_angle (vote_angle),
    .vote_r     (vote_r),
    .busy       (busy),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .peak_count (peak_count),
    .peak_angle (peak_angle),
    .peak_rbin  (peak_rbin),
    .err_range  (err_range),
    .err_drop   (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: cell counts keyed by angle*256 + r_bin, plus peak and sticky range error.
  int unsigned mcnt [int];
  int          m_peak, m_pa, m_pr;
  bit          m_err;

  typedef struct {
    int angle;
    int r;
    bit exp_ok;
    int exp_addr;
  } vec_t;

  vec_t vecs [9];

  function automatic int mget(input int a);
    return mcnt.exists(a) ? int'(mcnt[a]) : 0;
  endfunction

  function automatic void model_reset();
    mcnt.delete();
    m_peak = 0;
    m_pa   = 0;
    m_pr   = 0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_vote(input int angle, input int r);
    int biased;
    int bin;
    int a;
    int c;
    biased = r + 800;
    bin    = biased / 8;
    if (angle >= 180 || biased < 0 || bin > 255) begin
      m_err = 1'b1;
    end else begin
      a = angle * 256 + bin;
      c = mget(a);
      if (c < 255) c = c + 1;
      mcnt[a] = c;
      if (c > m_peak) begin
        m_peak = c;
        m_pa   = angle;
        m_pr   = bin;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic vote(input bit v, input int angle, input int r);
    vote_valid = v;
    vote_angle = 8'(angle);
    vote_r     = 13'(r);
    if (v) model_vote(angle, r);
    tick();
    vote_valid = 1'b0;
  endtask

  task automatic drain();
    tick();
    tick();
  endtask

  task automatic read_cell(input int addr, output int val);
    rd_addr = 16'(addr);
    tick();
    tick();
    val = int'(rd_data);
  endtask

  task automatic check_peak(input string name);
    check({name, "_count"}, int'(peak_count), m_peak);
    check({name, "_angle"}, int'(peak_angle), m_pa);
    check({name, "_rbin"},  int'(peak_rbin),  m_pr);
  endtask

  int val;
  int n;
  bit exp_err;
  int pool_a [8];
  int pool_r [8];

  initial begin
    reset = 1'b1; clear = 1'b0; vote_valid = 1'b0;
    vote_angle = '0; vote_r = '0; rd_addr = '0;
    model_reset();

    // Reset values
    tick(); tick(); tick();
    check("rst_busy",  int'(busy), 0);
    check("rst_peak",  int'(peak_count), 0);
    check("rst_pang",  int'(peak_angle), 0);
    check("rst_prbin", int'(peak_rbin), 0);
    check("rst_erng",  int'(err_range), 0);
    check("rst_edrop", int'(err_drop), 0);
    check("rst_rdata", int'(rd_data), 0);

    // Reset wins over clear in the same cycle
    clear = 1'b1;
    tick();
    reset = 1'b0; clear = 1'b0;
    tick();
    check("rst_over_clear_busy", int'(busy), 0);

    // Reset aborts a clear in progress
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("midclear_busy_high", int'(busy), 1);
    reset = 1'b1; tick(); reset = 1'b0; tick();
    check("midclear_abort_busy", int'(busy), 0);

    // Range error sticks, then votes in flight when clear hits are discarded
    vote(1'b1, 200, 0);
    tick();
    check("pre_err_range", int'(err_range), 1);
    vote(1'b1, 45, 100);
    vote(1'b1, 45, 100);
    clear = 1'b1; vote_valid = 1'b1; vote_angle = 8'd45; vote_r = 13'd100;
    tick();
    clear = 1'b0;
    vote_valid = 1'b1;
    tick();
    vote_valid = 1'b0;
    model_reset();
    check("clr_busy",      int'(busy), 1);
    check("clr_err_drop",  int'(err_drop), 1);
    check("clr_err_range", int'(err_range), 0);
    check("clr_peak",      int'(peak_count), 0);
    n = 1;
    while (busy && n < 70000) begin
      tick();
      n++;
    end
    check("clr_busy_cycles", n, 65536);
    check("clr_peak_after", int'(peak_count), 0);
    check("clr_err_drop_sticky", int'(err_drop), 1);
    read_cell('h0000, val); check("clr_cell_0000", val, 0);
    read_cell('h2D70, val); check("clr_cell_2d70", val, 0);
    read_cell('hFFFF, val); check("clr_cell_ffff", val, 0);

    // Vector table: single votes, each read back at the earliest visible cycle
    vecs[0] = '{45,   100,  1'b1, 'h2D70};
    vecs[1] = '{179,  -800, 1'b1, 'hB300};
    vecs[2] = '{0,    -800, 1'b1, 'h0000};
    vecs[3] = '{5,    1247, 1'b1, 'h05FF};
    vecs[4] = '{7,    -793, 1'b1, 'h0700};
    vecs[5] = '{7,    -792, 1'b1, 'h0701};
    vecs[6] = '{180,  0,    1'b0, 'hB464};
    vecs[7] = '{0,    1248, 1'b0, 'h0000};
    vecs[8] = '{3,    -801, 1'b0, 'h03FF};
    exp_err = 1'b0;
    for (int i = 0; i < 9; i++) begin
      vote(1'b1, vecs[i].angle, vecs[i].r);
      drain();
      exp_err = exp_err | !vecs[i].exp_ok;
      check($sformatf("vec%0d_err_range", i), int'(err_range), int'(exp_err));
      read_cell(vecs[i].exp_addr, val);
      check($sformatf("vec%0d_cell", i), val, mget(vecs[i].exp_addr));
    end
    read_cell('h0000, val); check("alias_0000_unchanged", val, 1);
    check("single_peak_count", int'(peak_count), 1);
    check("single_peak_angle", int'(peak_angle), 45);
    check("single_peak_rbin",  int'(peak_rbin), 112);

    // Alternating two cells: gap-of-one reuse and peak tie handling
    for (int k = 0; k < 6; k++) vote(1'b1, (k % 2 == 1) ? 20 : 10, 0);
    drain();
    read_cell('h0A64, val); check("alt_cell_a", val, 3);
    read_cell('h1464, val); check("alt_cell_b", val, 3);
    check("alt_peak_count", int'(peak_count), 3);
    check("alt_peak_angle", int'(peak_angle), 10);
    check_peak("alt_model_peak");

    // Back-to-back same cell relies on write bypass
    for (int k = 0; k < 5; k++) vote(1'b1, 11, 0);
    drain();
    read_cell('h0B64, val); check("b2b_cell", val, 5);
    check("b2b_peak_count", int'(peak_count), 5);
    check("b2b_peak_angle", int'(peak_angle), 11);

    // Random stream over a small pool of colliding cells
    pool_a = '{12, 12, 13, 100, 179, 0, 50, 50};
    pool_r = '{0,  7,  0,  -800, 1247, 500, 500, 508};
    for (int k = 0; k < 1500; k++) begin
      int p;
      p = int'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 9) == 0) vote(1'b1, int'($urandom_range(180, 255)), pool_r[p]);
        else vote(1'b1, pool_a[p], pool_r[p]);
      end else begin
        vote(1'b0, 0, 0);
      end
    end
    drain();
    for (int p = 0; p < 8; p++) begin
      int a;
      a = pool_a[p] * 256 + (pool_r[p] + 800) / 8;
      read_cell(a, val);
      check($sformatf("rand_cell_%0d", p), val, mget(a));
    end
    check_peak("rand_peak");
    check("rand_err_range", int'(err_range), int'(m_err));

    // Saturation
    for (int k = 0; k < 300; k++) vote(1'b1, 0, -800);
    drain();
    read_cell('h0000, val); check("sat_cell", val, 255);
    check("sat_peak_count", int'(peak_count), 255);
    check_peak("sat_model_peak");
    check("final_err_drop", int'(err_drop), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
